// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 1-write general-purpose register file with optional
// write-to-read bypass, a per-register busy scoreboard for hazard detection,
// and a sequenced clear of every entry after reset.
module regfile_sb #(
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input  logic          clk,
   input  logic          rst,
   output logic          ready,
   input  logic [AW-1:0] rs,
   output logic [DW-1:0] rsdata,
   output logic          rs_busy,
   input  logic [AW-1:0] rt,
   output logic [DW-1:0] rtdata,
   output logic          rt_busy,
   input  logic          Regwen,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          sb_set,
   input  logic [AW-1:0] sb_addr
);

   localparam int DEPTH = 1 << AW;
   localparam bit BYP   = (BYPASS != 0);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
   logic [DW-1:0]    rf_q [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;

   logic run;
   logic clr_en;
   logic wr_en;
   logic set_en;
   logic rs_hit;
   logic rt_hit;

   // State register: reset (re)starts the clear sequence from entry 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // Next-state: walk the clear pointer, leave CLEAR after the last entry.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      if (state_q == S_CLEAR) begin
         clr_ptr_d = clr_ptr_q + AW'(1);
         if (clr_ptr_q == {AW{1'b1}}) begin
            state_d = S_RUN;
         end
      end
   end

   // Outputs/enables: writes and scoreboard sets only take effect in RUN.
   always_comb begin
      run    = (state_q == S_RUN);
      ready  = run;
      clr_en = (state_q == S_CLEAR) && !rst;
      wr_en  = run && Regwen && (waddr != '0);
      set_en = run && sb_set && (sb_addr != '0);
   end

   // Storage: clear sequence owns the array in CLEAR, WB port in RUN.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         rf_q[clr_ptr_q] <= '0;
      end else if (wr_en) begin
         rf_q[waddr] <= wdata;
      end
   end

   // Scoreboard next state: a write retires the producer, a set applied
   // afterwards wins so a newer in-flight producer keeps the entry busy.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_ptr_q] = 1'b0;
      end else begin
         if (wr_en) begin
            busy_d[waddr] = 1'b0;
         end
         if (set_en) begin
            busy_d[sb_addr] = 1'b1;
         end
      end
   end

   // Scoreboard register; cleared by the sequence, not by rst directly.
   always_ff @(posedge clk) begin
      busy_q <= busy_d;
   end

   // Read ports: r0 and the whole file read as zero until ready; a matching
   // same-cycle write is forwarded and its pending hazard is hidden.
   always_comb begin
      rs_hit  = BYP && wr_en && (waddr == rs);
      rt_hit  = BYP && wr_en && (waddr == rt);
      rsdata  = '0;
      rtdata  = '0;
      rs_busy = 1'b0;
      rt_busy = 1'b0;
      if (run && (rs != '0)) begin
         rsdata  = rs_hit ? wdata : rf_q[rs];
         rs_busy = busy_q[rs] && !rs_hit;
      end
      if (run && (rt != '0)) begin
         rtdata  = rt_hit ? wdata : rf_q[rt];
         rt_busy = busy_q[rt] && !rt_hit;
      end
   end

endmodule
